alu_add_sequencer: RTL
======================

ALU_ADD_SEQUENCER -- requirements
Module: alu_add_sequencer

Interface
REQ-001 SHALL have parameter NUM_SLICES, default 4, meaning the number of 8-bit slices per operand (operand width = 8*NUM_SLICES).
REQ-002 SHALL have port CLK, input, 1, the single clock; all state updates on rising edge.
REQ-003 SHALL have port RST, input, 1, reset; asynchronous, active-high.
REQ-004 SHALL have port IN_VALID, input, 1, request present.
REQ-005 SHALL have port IN_READY, output, 1, block can accept a request.
REQ-006 SHALL have port OP, input, 2, operation: 0 ADD, 1 ADC, 2 SUB, 3 SBC.
REQ-007 SHALL have ports A and B, input, 8*NUM_SLICES each, operands.
REQ-008 SHALL have port CARRY_IN, input, 1, carry for ADC/SBC (carry = not-borrow).
REQ-009 SHALL have port OUT_VALID, output, 1, result held.
REQ-010 SHALL have port OUT_READY, input, 1, consumer takes result.
REQ-011 SHALL have port RESULT, output, 8*NUM_SLICES, sum.
REQ-012 SHALL have port CARRY_OUT, output, 1, final carry.
REQ-013 SHALL have ports ZERO and OVERFLOW, output, 1 each, flags (see REQ-027).

Function
REQ-014 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-015 SHALL drive IN_READY high only in IDLE, combinationally from state.
REQ-016 SHALL accept on a rising edge where IDLE and IN_VALID; latch A, B (B inverted for SUB/SBC), carry-in (ADD 0, ADC CARRY_IN, SUB 1, SBC CARRY_IN), slice index = 0; go to BUSY.
REQ-017 SHALL, per BUSY cycle, form P = a_byte XOR b_byte and G = a_byte AND b_byte for slice[index], drive the lookahead with running carry as C_IN.
REQ-018 SHALL register sum byte = P XOR {CARRYS[6:0], C_IN} into RESULT slice[index] and update running carry to CARRYS[7] on each BUSY edge.
REQ-019 SHALL increment index each BUSY edge; after slice NUM_SLICES-1 go to DONE.
REQ-020 SHALL assert OUT_VALID exactly in DONE; with NUM_SLICES=4, OUT_VALID rises 4 edges after the accept edge.
REQ-021 SHALL hold RESULT, CARRY_OUT, ZERO, OVERFLOW stable while OUT_VALID and not OUT_READY.
REQ-022 SHALL leave DONE for IDLE on an edge with OUT_READY; no same-edge accept (IN_READY low in DONE), so minimum throughput is one op per NUM_SLICES+2 cycles.
REQ-023 SHALL ignore IN_VALID, OP, A, B, CARRY_IN outside the accept edge; input changes during BUSY do not affect the result.
REQ-024 SHALL wrap arithmetic modulo 2^(8*NUM_SLICES); carry beyond MSB appears only on CARRY_OUT.

Reset
REQ-025 SHALL on RST, immediately and regardless of state (including mid-BUSY), force state IDLE, index 0, RESULT 0, CARRY_OUT 0, ZERO 0, OVERFLOW 0, OUT_VALID 0; in-flight operation is discarded.
REQ-026 SHALL assert IN_READY on the first edge-free cycle after RST deasserts.

Configuration
REQ-027 SHALL compile ZERO and OVERFLOW logic only when ALU_SEQ_FLAGS_EN is defined: ZERO = RESULT all-zero; OVERFLOW = CARRYS[6] XOR CARRYS[7] of final slice; both registered with the last slice.
REQ-028 SHALL, without ALU_SEQ_FLAGS_EN, keep the ZERO and OVERFLOW ports and tie them to 0.

Structure
REQ-029 SHALL place the FSM state enum and the OP encoding enum in the shared ALU package.
REQ-030 SHALL instantiate exactly one sub-module, the existing alu_lookahead 8-bit carry block, shared across all slices.

Verification
REQ-031 SHALL cover ADD A=0x000000FF, B=0x00000001 -> after 4 cycles RESULT=0x00000100, CARRY_OUT=0, ZERO=0, OVERFLOW=0.
REQ-032 SHALL cover ADD A=0xFFFFFFFF, B=0x00000001 -> RESULT=0x00000000, CARRY_OUT=1, ZERO=1 (flags build), OVERFLOW=0.
REQ-033 SHALL cover SUB A=0x80000000, B=0x00000001 -> RESULT=0x7FFFFFFF, CARRY_OUT=1, OVERFLOW=1 (flags build).
REQ-034 SHALL cover ADC A=0x7FFFFFFF, B=0, CARRY_IN=1 -> RESULT=0x80000000, OVERFLOW=1; SBC A=5, B=3, CARRY_IN=0 -> RESULT=1, CARRY_OUT=1.
REQ-035 SHALL cover OUT_READY held low 10 cycles -> outputs stable, IN_READY low; IN_VALID pulsed then -> not accepted until after OUT_READY edge.
REQ-036 SHALL cover RST asserted at index 2 -> outputs zero immediately, IN_READY high after release, next ADD 2+2 -> RESULT=4.

Source files
------------

// File: rtl/alu_add_sequencer_pkg.sv
// Shared ALU package: FSM state and operation encodings plus small decode
// helpers used by the slice-serial add sequencer.
package alu_add_sequencer_pkg;

  localparam int SLICE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_ADC = 2'd1,
    OP_SUB = 2'd2,
    OP_SBC = 2'd3
  } op_e;

  // Subtraction is A + ~B + carry, so B is inverted for SUB/SBC.
  function automatic logic op_is_sub(input op_e op);
    return (op == OP_SUB) || (op == OP_SBC);
  endfunction

  // Initial carry: ADD 0, SUB 1 (two's complement), ADC/SBC take the caller's carry.
  function automatic logic op_carry_in(input op_e op, input logic cin);
    logic c;
    case (op)
      OP_ADD:  c = 1'b0;
      OP_SUB:  c = 1'b1;
      default: c = cin;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu_add_sequencer_lookahead.sv
// alu_lookahead: 8-bit carry block. CARRYS[i] is the carry out of bit i
// given propagate P, generate G and carry into bit 0.
module alu_lookahead (
  input  logic [7:0] P,
  input  logic [7:0] G,
  input  logic       C_IN,
  output logic [7:0] CARRYS
);

  logic c;

  // Carry recurrence c[i] = G[i] | P[i]&c[i-1]; flattens to lookahead terms.
  always_comb begin
    CARRYS = '0;
    c      = C_IN;
    for (int i = 0; i < 8; i++) begin
      c         = G[i] | (P[i] & c);
      CARRYS[i] = c;
    end
  end

endmodule

// File: rtl/alu_add_sequencer.sv
// alu_add_sequencer: multi-byte add/subtract that processes one 8-bit slice
// per cycle through a single shared alu_lookahead block.
// Optional flags: define ALU_SEQ_FLAGS_EN to build ZERO/OVERFLOW logic;
// otherwise both ports are tied to 0.
module alu_add_sequencer
  import alu_add_sequencer_pkg::*;
#(
  parameter int NUM_SLICES = 4
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      IN_VALID,
  output logic                      IN_READY,
  input  logic [1:0]                OP,
  input  logic [8*NUM_SLICES-1:0]   A,
  input  logic [8*NUM_SLICES-1:0]   B,
  input  logic                      CARRY_IN,
  output logic                      OUT_VALID,
  input  logic                      OUT_READY,
  output logic [8*NUM_SLICES-1:0]   RESULT,
  output logic                      CARRY_OUT,
  output logic                      ZERO,
  output logic                      OVERFLOW
);

  localparam int W     = SLICE_W * NUM_SLICES;
  localparam int IDX_W = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;

  state_e           state, state_nxt;
  logic [IDX_W-1:0] idx;
  logic [W-1:0]     a_q, b_q;
  logic             carry_q;
  op_e              op_v;
  logic             accept, last_slice;
  logic [7:0]       a_byte, b_byte, p, g, carrys, sum_byte;

  assign op_v       = op_e'(OP);
  assign accept     = (state == ST_IDLE) && IN_VALID;
  assign last_slice = (idx == IDX_W'(NUM_SLICES - 1));

  assign a_byte   = a_q[{idx, 3'b000} +: 8];
  assign b_byte   = b_q[{idx, 3'b000} +: 8];
  assign p        = a_byte ^ b_byte;
  assign g        = a_byte & b_byte;
  assign sum_byte = p ^ {carrys[6:0], carry_q};

  alu_lookahead u_lookahead (
    .P      (p),
    .G      (g),
    .C_IN   (carry_q),
    .CARRYS (carrys)
  );

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next state and handshake outputs, decoded from state only.
  always_comb begin
    state_nxt = state;
    IN_READY  = 1'b0;
    OUT_VALID = 1'b0;
    case (state)
      ST_IDLE: begin
        IN_READY = 1'b1;
        if (IN_VALID) state_nxt = ST_BUSY;
      end
      ST_BUSY: begin
        if (last_slice) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        OUT_VALID = 1'b1;
        if (OUT_READY) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Operand latch on accept, then one result slice and carry per BUSY edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      a_q       <= '0;
      b_q       <= '0;
      carry_q   <= 1'b0;
      idx       <= '0;
      RESULT    <= '0;
      CARRY_OUT <= 1'b0;
    end else if (accept) begin
      a_q     <= A;
      b_q     <= op_is_sub(op_v) ? ~B : B;
      carry_q <= op_carry_in(op_v, CARRY_IN);
      idx     <= '0;
    end else if (state == ST_BUSY) begin
      RESULT[{idx, 3'b000} +: 8] <= sum_byte;
      carry_q                    <= carrys[7];
      if (last_slice) begin
        idx       <= '0;
        CARRY_OUT <= carrys[7];
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

`ifdef ALU_SEQ_FLAGS_EN
  logic [W-1:0] next_result;

  // Full result as it will look after this edge, so ZERO sees the last slice.
  always_comb begin
    next_result                     = RESULT;
    next_result[{idx, 3'b000} +: 8] = sum_byte;
  end

  // Flags are captured together with the final slice.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ZERO     <= 1'b0;
      OVERFLOW <= 1'b0;
    end else if ((state == ST_BUSY) && last_slice) begin
      ZERO     <= (next_result == '0);
      OVERFLOW <= carrys[6] ^ carrys[7];
    end
  end
`else
  assign ZERO     = 1'b0;
  assign OVERFLOW = 1'b0;
`endif

endmodule
